fetch_stage_ctrl: RTL and testbench
===================================

Name: fetch_stage_ctrl

Overview:
- Owns the program counter and the IF/ID pipeline register, directly upstream of the ID-stage hazard detection unit.
- Consumes that unit's PC-write and IF/ID-write enables to hold fetch on load-use and branch-operand stalls.
- Applies ID-resolved branch/jump redirects, squashing the wrong-path instruction into a NOP bubble.
- Tracks consecutive stall cycles with a watchdog flag for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- STALL_MAX, 8'd64, consecutive stall cycles at which StallTimeout sets.

Ports:
- Clk  in  1  pipeline clock.
- Rst_n  in  1  asynchronous active-low reset.
- PCWriteSel  in  1  1 = PC may update, 0 = hold PC (from hazard unit).
- IF_WriteSel_ID  in  1  1 = IF/ID may load, 0 = hold IF/ID (from hazard unit).
- BranchTaken  in  1  ID-stage branch resolved taken.
- BranchTarget  in  32  branch target address.
- Jump  in  1  ID-stage j/jal/jr.
- JumpTarget  in  32  jump target address.
- Instr_in  in  32  instruction memory read data for PC_out (combinational read).
- PC_out  out  32  current PC, instruction memory address.
- ID_Instr  out  32  IF/ID instruction.
- ID_PCPlus4  out  32  IF/ID PC+4.
- ID_Valid  out  1  IF/ID holds a real instruction.
- StallCount  out  8  consecutive PCWriteSel=0 cycles, saturating.
- StallTimeout  out  1  sticky watchdog flag.
- PerfCycles, PerfStalls, PerfFlushes  out  32 each  performance counters (see Optional Feature).

Behaviour:
- Reset (Rst_n=0, async, any time including mid-stall or mid-redirect):
  - PC_out=RESET_PC; ID_Instr=32'h0 (sll $0,$0,0 NOP); ID_PCPlus4=0; ID_Valid=0.
  - StallCount=0; StallTimeout=0; all Perf* = 0.
  - First rising edge after release loads IF/ID with the instruction at RESET_PC.
- Redirect = (BranchTaken | Jump) & PCWriteSel. Target = BranchTarget if BranchTaken, else JumpTarget. BranchTaken wins if both are asserted.
- Next-PC priority, evaluated each rising edge:
  1. PCWriteSel=0: PC holds. BranchTaken/Jump are ignored, because the hazard unit stalls branches whose operands are not ready, so the decision is invalid.
  2. Redirect: PC <= {Target[31:2],2'b00}.
  3. Otherwise: PC <= PC+4. Wraps modulo 2^32 at 32'hFFFF_FFFC -> 0.
- IF/ID register:
  - IF_WriteSel_ID=0: all IF/ID fields hold, including ID_Valid.
  - IF_WriteSel_ID=1 and Redirect: ID_Instr <= 0, ID_PCPlus4 <= 0, ID_Valid <= 0 (one-cycle flush bubble).
  - IF_WriteSel_ID=1, no Redirect: ID_Instr <= Instr_in, ID_PCPlus4 <= PC+4, ID_Valid <= 1.
- Enables are honoured independently.
  - PCWriteSel=0 with IF_WriteSel_ID=1 reloads the same instruction; this is legal, no error.
  - PCWriteSel=1 with IF_WriteSel_ID=0 drops the fetched word; this is legal.
- Latency: PC to ID_Instr is 1 cycle. Redirect costs exactly 1 bubble.
- StallCount:
  - Increments each edge with PCWriteSel=0 and saturates at 8'hFF.
  - Clears to 0 on any edge with PCWriteSel=1.
- StallTimeout:
  - Sets on the edge where StallCount transitions to STALL_MAX.
  - Sticky until reset.
  - STALL_MAX=0 disables it (never sets).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - PerfCycles increments every edge.
  - PerfStalls increments on edges with PCWriteSel=0.
  - PerfFlushes increments on edges where a flush bubble is written.
  - All three are 32-bit and wrap at 2^32.
- Undefined: the ports remain, tied to 32'h0, and no counter flops are inferred.

Test Plan:
- Reset release with RESET_PC=0 and sequential memory, no stalls -> PC_out 0,4,8,12 on successive edges; ID_Valid=0 in cycle 0, then 1; ID_PCPlus4 lags PC_out+4 by 1 cycle.
- PCWriteSel=IF_WriteSel_ID=0 for 3 cycles at PC=0x10 -> PC_out stays 0x10; ID_Instr unchanged; StallCount 1,2,3, then 0 on release; PC_out 0x14 on the next edge.
- BranchTaken=1, BranchTarget=0x40 (both enables=1) at PC=0x20 -> next PC_out=0x40; ID_Instr=0, ID_Valid=0 for 1 cycle; next ID_Instr = mem[0x40].
- BranchTaken=1 with PCWriteSel=0 -> PC holds, no flush; BranchTaken=1 and Jump=1 together (JumpTarget=0x80, BranchTarget=0x40) -> PC_out=0x40.
- STALL_MAX=4, PCWriteSel=0 for 300 cycles -> StallTimeout=1 after the 4th stall edge and stays 1; StallCount saturates at 0xFF; Rst_n pulse mid-stall clears all outputs immediately (asynchronously).
- FETCH_PERF_CNT_EN defined, 10 cycles with 2 stalls and 1 redirect -> PerfCycles=10, PerfStalls=2, PerfFlushes=1; macro undefined -> all three read 0.

Source files
------------

// File: rtl/fetch_stage_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage_ctrl: program counter and IF/ID register with stall, redirect |
// | flush and stall watchdog. Optional perf counters via FETCH_PERF_CNT_EN.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [7:0]  STALL_MAX = 8'd64
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        PCWriteSel,
  input  logic        IF_WriteSel_ID,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] Instr_in,
  output logic [31:0] PC_out,
  output logic [31:0] ID_Instr,
  output logic [31:0] ID_PCPlus4,
  output logic        ID_Valid,
  output logic [7:0]  StallCount,
  output logic        StallTimeout,
  output logic [31:0] PerfCycles,
  output logic [31:0] PerfStalls,
  output logic [31:0] PerfFlushes
);

  logic        w_redirect;
  logic        w_flush;
  logic [31:0] w_target;
  logic [31:0] w_pcPlus4;
  logic [7:0]  w_nextStall;
  logic        w_timeoutHit;

  // A stalled PC means the branch operands were not ready, so its decision is ignored.
  always_comb begin
    w_redirect   = (BranchTaken | Jump) & PCWriteSel;
    w_flush      = w_redirect & IF_WriteSel_ID;
    w_target     = BranchTaken ? BranchTarget : JumpTarget;
    w_pcPlus4    = PC_out + 32'd4;
    w_nextStall  = 8'h00;
    if (!PCWriteSel) begin
      w_nextStall = (StallCount == 8'hFF) ? 8'hFF : StallCount + 8'd1;
    end
    w_timeoutHit = (STALL_MAX != 8'd0) && !PCWriteSel &&
                   (StallCount != STALL_MAX) && (w_nextStall == STALL_MAX);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      PC_out       <= RESET_PC;
      ID_Instr     <= 32'h0;
      ID_PCPlus4   <= 32'h0;
      ID_Valid     <= 1'b0;
      StallCount   <= 8'h00;
      StallTimeout <= 1'b0;
    end else begin
      if (w_redirect) begin
        PC_out <= w_target & 32'hFFFF_FFFC;
      end else if (PCWriteSel) begin
        PC_out <= w_pcPlus4;
      end

      if (IF_WriteSel_ID) begin
        if (w_redirect) begin
          ID_Instr   <= 32'h0;
          ID_PCPlus4 <= 32'h0;
          ID_Valid   <= 1'b0;
        end else begin
          ID_Instr   <= Instr_in;
          ID_PCPlus4 <= w_pcPlus4;
          ID_Valid   <= 1'b1;
        end
      end

      StallCount <= w_nextStall;
      if (w_timeoutHit) begin
        StallTimeout <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perfCycles;
  logic [31:0] r_perfStalls;
  logic [31:0] r_perfFlushes;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_perfCycles  <= 32'h0;
      r_perfStalls  <= 32'h0;
      r_perfFlushes <= 32'h0;
    end else begin
      r_perfCycles <= r_perfCycles + 32'd1;
      if (!PCWriteSel) begin
        r_perfStalls <= r_perfStalls + 32'd1;
      end
      if (w_flush) begin
        r_perfFlushes <= r_perfFlushes + 32'd1;
      end
    end
  end

  assign PerfCycles  = r_perfCycles;
  assign PerfStalls  = r_perfStalls;
  assign PerfFlushes = r_perfFlushes;
`else
  logic w_unusedFlush;
  assign w_unusedFlush = w_flush;
  assign PerfCycles    = 32'h0;
  assign PerfStalls    = 32'h0;
  assign PerfFlushes   = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_stage_ctrl: directed self-checking bench for fetch_stage_ctrl.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_fetch_stage_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        PCWriteSel;
  logic        IF_WriteSel_ID;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] Instr_in;
  logic [31:0] PC_out;
  logic [31:0] ID_Instr;
  logic [31:0] ID_PCPlus4;
  logic        ID_Valid;
  logic [7:0]  StallCount;
  logic        StallTimeout;
  logic [31:0] PerfCycles;
  logic [31:0] PerfStalls;
  logic [31:0] PerfFlushes;

  int checks = 0;
  int errors = 0;
  int mCycles = 0;
  int mStalls = 0;
  int mFlushes = 0;

  localparam logic [31:0] c_memKey = 32'hC0DE_0001;

  fetch_stage_ctrl #(.RESET_PC(32'h0), .STALL_MAX(8'd4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .PCWriteSel(PCWriteSel), .IF_WriteSel_ID(IF_WriteSel_ID),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Jump(Jump),
    .JumpTarget(JumpTarget), .Instr_in(Instr_in), .PC_out(PC_out), .ID_Instr(ID_Instr),
    .ID_PCPlus4(ID_PCPlus4), .ID_Valid(ID_Valid), .StallCount(StallCount),
    .StallTimeout(StallTimeout), .PerfCycles(PerfCycles), .PerfStalls(PerfStalls),
    .PerfFlushes(PerfFlushes)
  );

  always #5 Clk = ~Clk;

  // Instruction memory: every word is distinct and nonzero, derived from its address.
  function automatic logic [31:0] mem(input logic [31:0] addr);
    return addr ^ c_memKey;
  endfunction

  assign Instr_in = mem(PC_out);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (Rst_n) begin
      mCycles++;
      if (!PCWriteSel) mStalls++;
      if (IF_WriteSel_ID && PCWriteSel && (BranchTaken || Jump)) mFlushes++;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic checkIfId(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] plus4, input logic valid);
    check({tag, "_pc"}, PC_out, pc);
    check({tag, "_instr"}, ID_Instr, instr);
    check({tag, "_plus4"}, ID_PCPlus4, plus4);
    check({tag, "_valid"}, {31'h0, ID_Valid}, {31'h0, valid});
  endtask

  task automatic checkPerf(input string tag);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_cycles"}, PerfCycles, mCycles);
    check({tag, "_stalls"}, PerfStalls, mStalls);
    check({tag, "_flushes"}, PerfFlushes, mFlushes);
`else
    check({tag, "_cycles"}, PerfCycles, 32'h0);
    check({tag, "_stalls"}, PerfStalls, 32'h0);
    check({tag, "_flushes"}, PerfFlushes, 32'h0);
`endif
  endtask

  task automatic checkResetState(input string tag);
    checkIfId(tag, 32'h0, 32'h0, 32'h0, 1'b0);
    check({tag, "_stallcnt"}, {24'h0, StallCount}, 32'h0);
    check({tag, "_timeout"}, {31'h0, StallTimeout}, 32'h0);
    checkPerf(tag);
  endtask

  initial begin
    Rst_n = 1'b0;
    PCWriteSel = 1'b1;
    IF_WriteSel_ID = 1'b1;
    BranchTaken = 1'b0;
    BranchTarget = 32'h0;
    Jump = 1'b0;
    JumpTarget = 32'h0;

    #12;
    checkResetState("reset");
    Rst_n = 1'b1;

    // Sequential fetch from RESET_PC
    tick(); checkIfId("seq1", 32'h4, mem(32'h0), 32'h4, 1'b1);
    tick(); checkIfId("seq2", 32'h8, mem(32'h4), 32'h8, 1'b1);
    tick(); checkIfId("seq3", 32'hC, mem(32'h8), 32'hC, 1'b1);
    tick(); checkIfId("seq4", 32'h10, mem(32'hC), 32'h10, 1'b1);

    // Three-cycle full stall at 0x10
    PCWriteSel = 1'b0; IF_WriteSel_ID = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkIfId("stall", 32'h10, mem(32'hC), 32'h10, 1'b1);
      check("stall_cnt", {24'h0, StallCount}, i);
    end
    check("stall_no_timeout", {31'h0, StallTimeout}, 32'h0);
    PCWriteSel = 1'b1; IF_WriteSel_ID = 1'b1;
    tick(); checkIfId("release", 32'h14, mem(32'h10), 32'h14, 1'b1);
    check("release_cnt", {24'h0, StallCount}, 32'h0);
    tick(); tick(); tick();
    check("pc_at_20", PC_out, 32'h20);

    // Taken branch from 0x20 to 0x40: one bubble
    BranchTaken = 1'b1; BranchTarget = 32'h40;
    tick(); checkIfId("br_flush", 32'h40, 32'h0, 32'h0, 1'b0);
    BranchTaken = 1'b0;
    tick(); checkIfId("br_target", 32'h44, mem(32'h40), 32'h44, 1'b1);

    // Branch during PC stall is ignored; IF/ID reloads the same word
    PCWriteSel = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h80;
    tick(); checkIfId("br_stalled", 32'h44, mem(32'h44), 32'h48, 1'b1);
    check("br_stalled_cnt", {24'h0, StallCount}, 32'h1);

    // Branch wins over jump
    PCWriteSel = 1'b1; BranchTarget = 32'h40; Jump = 1'b1; JumpTarget = 32'h80;
    tick(); checkIfId("br_vs_jmp", 32'h40, 32'h0, 32'h0, 1'b0);
    check("br_vs_jmp_cnt", {24'h0, StallCount}, 32'h0);

    // Jump alone, misaligned target gets word-aligned
    BranchTaken = 1'b0; JumpTarget = 32'h83;
    tick(); checkIfId("jmp", 32'h80, 32'h0, 32'h0, 1'b0);
    Jump = 1'b0;

    // PC advances while IF/ID holds the bubble
    IF_WriteSel_ID = 1'b0;
    tick(); checkIfId("ifid_hold", 32'h84, 32'h0, 32'h0, 1'b0);
    IF_WriteSel_ID = 1'b1;
    tick(); checkIfId("resume", 32'h88, mem(32'h84), 32'h88, 1'b1);
    checkPerf("perf_mid");

    // PC wraps from 0xFFFF_FFFC to 0
    Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
    tick(); check("wrap_jmp", PC_out, 32'hFFFF_FFFC);
    Jump = 1'b0;
    tick(); checkIfId("wrap", 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1'b1);

    // Long stall: watchdog at STALL_MAX=4, counter saturates
    PCWriteSel = 1'b0; IF_WriteSel_ID = 1'b0;
    tick(); tick(); tick();
    check("wd_before", {31'h0, StallTimeout}, 32'h0);
    tick();
    check("wd_set", {31'h0, StallTimeout}, 32'h1);
    check("wd_cnt4", {24'h0, StallCount}, 32'h4);
    for (int i = 5; i <= 255; i++) tick();
    check("sat_ff", {24'h0, StallCount}, 32'hFF);
    for (int i = 0; i < 45; i++) tick();
    check("sat_hold", {24'h0, StallCount}, 32'hFF);
    check("wd_sticky", {31'h0, StallTimeout}, 32'h1);
    check("long_pc", PC_out, 32'h0);
    checkPerf("perf_long");
    PCWriteSel = 1'b1; IF_WriteSel_ID = 1'b1;
    tick();
    check("unstall_cnt", {24'h0, StallCount}, 32'h0);
    check("wd_sticky2", {31'h0, StallTimeout}, 32'h1);

    // Asynchronous reset in the middle of a stall
    PCWriteSel = 1'b0; IF_WriteSel_ID = 1'b0;
    tick(); tick();
    Rst_n = 1'b0;
    mCycles = 0; mStalls = 0; mFlushes = 0;
    #1;
    checkResetState("async_rst");
    PCWriteSel = 1'b1; IF_WriteSel_ID = 1'b1;
    #2;
    Rst_n = 1'b1;
    tick(); checkIfId("post_rst", 32'h4, mem(32'h0), 32'h4, 1'b1);
    check("post_rst_wd", {31'h0, StallTimeout}, 32'h0);

    // Ten cycles with two stalls and one redirect
    tick(); tick(); tick();
    PCWriteSel = 1'b0;
    tick(); tick();
    PCWriteSel = 1'b1; Jump = 1'b1; JumpTarget = 32'h100;
    tick();
    Jump = 1'b0;
    tick(); tick(); tick();
    check("perf10_pc", PC_out, 32'h10C);
    check("perf10_model_cycles", mCycles, 32'd10);
    checkPerf("perf10");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
